seq_fill_engine: RTL and testbench

- Parametrised in-place gap-fill engine for sequences of (value, credibility) byte pairs in a single-port synchronous memory.
- Entry i sits at BASE+2i (value) and BASE+2i+1 (credibility).
- Each zero value is replaced by the last non-zero value, or left as zero when hold is disabled. Credibility decays by a programmable step per consecutive gap.
- Adds abort, configurable decay, hold-disable and a fill counter.

---
 rtl/seq_fill_engine.sv | 191 +++++++++++++++++++
 tb/tb_seq_fill_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_fill_engine.sv
// rtl/seq_fill_engine.sv - in-place gap-fill engine for (value, credibility) byte-pair sequences
module seq_fill_engine #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int LEN_W    = 10,
  parameter int CRED_W   = 8,
  parameter int CRED_MAX = 31
) (
  input  logic              I_CLOCK,
  input  logic              I_RESET,
  input  logic              I_START,
  input  logic              I_ABORT,
  input  logic [ADDR_W-1:0] I_ADD,
  input  logic [LEN_W-1:0]  I_K,
  input  logic [CRED_W-1:0] I_DECAY,
  input  logic              I_HOLD_EN,
  output logic [ADDR_W-1:0] O_MEMORY_ADDRESS,
  output logic              O_MEMORY_ENABLE,
  output logic [DATA_W-1:0] O_MEMORY_WRITE_DATA,
  output logic              O_MEMORY_WRITE_ENABLE,
  input  logic [DATA_W-1:0] I_MEMORY_READ_DATA,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic [LEN_W-1:0]  O_FILL_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WRV  = 3'd3,
    S_WRC  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CRED_MAX);

  // Credibility goes out on the data bus zero-extended or truncated to DATA_W.
  function automatic logic [DATA_W-1:0] cred_to_data(input logic [CRED_W-1:0] c);
    logic [DATA_W+CRED_W-1:0] wide;
    wide = {{DATA_W{1'b0}}, c};
    return wide[DATA_W-1:0];
  endfunction

  state_t            state, state_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [LEN_W-1:0]  k_q, k_n, idx_q, idx_n, fill_q, fill_n;
  logic [CRED_W-1:0] decay_q, decay_n, cred_q, cred_n;
  logic              hold_q, hold_n;
  logic [DATA_W-1:0] cap_q, cap_n, last_q, last_n;
  logic [ADDR_W-1:0] addr_q, addr_n, entry_addr;
  logic              en_q, en_n, we_q, we_n, busy_q, busy_n, done_q, done_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              in_run;

  assign O_MEMORY_ADDRESS      = addr_q;
  assign O_MEMORY_ENABLE       = en_q;
  assign O_MEMORY_WRITE_DATA   = wdata_q;
  assign O_MEMORY_WRITE_ENABLE = we_q;
  assign O_BUSY                = busy_q;
  assign O_DONE                = done_q;
  assign O_FILL_COUNT          = fill_q;

  // Next-state, datapath updates and the registered output values for the state being entered.
  always_comb begin
    state_n    = state;
    base_n     = base_q;
    k_n        = k_q;
    decay_n    = decay_q;
    hold_n     = hold_q;
    idx_n      = idx_q;
    last_n     = last_q;
    cred_n     = cred_q;
    cap_n      = cap_q;
    fill_n     = fill_q;
    addr_n     = '0;
    en_n       = 1'b0;
    we_n       = 1'b0;
    wdata_n    = '0;
    in_run     = (state == S_RD) || (state == S_CAP) || (state == S_WRV) || (state == S_WRC);

    if (I_ABORT && in_run) begin
      // Abort discards the entry in progress; nothing else is updated.
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (I_START) begin
            base_n  = I_ADD;
            k_n     = I_K;
            decay_n = I_DECAY;
            hold_n  = I_HOLD_EN;
            idx_n   = '0;
            last_n  = '0;
            cred_n  = '0;
            fill_n  = '0;
            state_n = (I_K != '0) ? S_RD : S_DONE;
          end
        end
        S_RD: state_n = S_CAP;
        S_CAP: begin
          cap_n   = I_MEMORY_READ_DATA;
          state_n = S_WRV;
        end
        S_WRV: begin
          if (cap_q != '0) begin
            last_n = cap_q;
            cred_n = CRED_FULL;
          end else begin
            cred_n = (cred_q > decay_q) ? (cred_q - decay_q) : '0;
            fill_n = fill_q + LEN_W'(1);
          end
          state_n = S_WRC;
        end
        S_WRC: begin
          if (idx_q == k_q - LEN_W'(1)) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx_q + LEN_W'(1);
            state_n = S_RD;
          end
        end
        S_DONE: if (!I_START) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end

    entry_addr = base_n + ADDR_W'({idx_n, 1'b0});
    case (state_n)
      S_RD: begin
        en_n   = 1'b1;
        addr_n = entry_addr;
      end
      S_WRV: begin
        en_n    = 1'b1;
        we_n    = 1'b1;
        addr_n  = entry_addr;
        wdata_n = (cap_n != '0) ? cap_n : (hold_n ? last_n : '0);
      end
      S_WRC: begin
        en_n    = 1'b1;
        we_n    = 1'b1;
        addr_n  = entry_addr + ADDR_W'(1);
        wdata_n = cred_to_data(cred_n);
      end
      default: ;
    endcase
    busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n = (state_n == S_DONE);
  end

  // State, datapath and output registers; asynchronous reset clears everything.
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state   <= S_IDLE;
      base_q  <= '0;
      k_q     <= '0;
      decay_q <= '0;
      hold_q  <= 1'b0;
      idx_q   <= '0;
      last_q  <= '0;
      cred_q  <= '0;
      cap_q   <= '0;
      fill_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      base_q  <= base_n;
      k_q     <= k_n;
      decay_q <= decay_n;
      hold_q  <= hold_n;
      idx_q   <= idx_n;
      last_q  <= last_n;
      cred_q  <= cred_n;
      cap_q   <= cap_n;
      fill_q  <= fill_n;
      addr_q  <= addr_n;
      en_q    <= en_n;
      we_q    <= we_n;
      wdata_q <= wdata_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_fill_engine.sv
// tb/tb_seq_fill_engine.sv - randomized model-based bench for seq_fill_engine
module tb_seq_fill_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort_r, hold_en;
  logic [15:0] add;
  logic [9:0]  k_in;
  logic [7:0]  decay;
  logic [15:0] mem_addr;
  logic        mem_en, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy, done;
  logic [9:0]  fill;

  seq_fill_engine dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_START(start), .I_ABORT(abort_r),
    .I_ADD(add), .I_K(k_in), .I_DECAY(decay), .I_HOLD_EN(hold_en),
    .O_MEMORY_ADDRESS(mem_addr), .O_MEMORY_ENABLE(mem_en),
    .O_MEMORY_WRITE_DATA(mem_wdata), .O_MEMORY_WRITE_ENABLE(mem_we),
    .I_MEMORY_READ_DATA(mem_rdata), .O_BUSY(busy), .O_DONE(done), .O_FILL_COUNT(fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    int en; int we; int addr; int data; int busy; int done; int fill;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         abort_at_g, rec_cnt, plan_fill;
  bit         stopped;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic void add_rec(input int en, we, a, d, b, dn, f);
    rec_t r;
    if (stopped) return;
    r.en = en; r.we = we; r.addr = a & 65535; r.data = d & 255;
    r.busy = b; r.done = dn; r.fill = f;
    exp_q.push_back(r);
    if (we != 0) ref_mem[r.addr[15:0]] = 8'(r.data);
    if (rec_cnt == abort_at_g) stopped = 1'b1;
    rec_cnt++;
  endfunction

  // Expected per-cycle bus activity derived from the gap-fill rules on whole entries.
  function automatic void plan_run(input int base, k, dec, hold, abort_at);
    int last = 0, cred = 0, fc = 0, a, v, nv;
    rec_t r;
    abort_at_g = abort_at; rec_cnt = 0; stopped = 1'b0;
    for (int j = 0; j < k && !stopped; j++) begin
      a  = (base + 2 * j) & 65535;
      v  = int'(ref_mem[a[15:0]]);
      nv = (v != 0) ? v : (hold != 0 ? last : 0);
      add_rec(1, 0, a, 0, 1, 0, fc);
      add_rec(0, 0, 0, 0, 1, 0, fc);
      add_rec(1, 1, a, nv, 1, 0, fc);
      if (!stopped) begin
        if (v != 0) begin last = v; cred = 31; end
        else begin cred = (cred > dec) ? cred - dec : 0; fc++; end
      end
      add_rec(1, 1, a + 1, cred, 1, 0, fc);
    end
    if (!stopped) begin
      add_rec(0, 0, 0, 0, 0, 1, fc);
      add_rec(0, 0, 0, 0, 0, 1, fc);
    end else begin
      r.en = 0; r.we = 0; r.addr = 0; r.data = 0; r.busy = 0; r.done = 0; r.fill = fc;
      exp_q.push_back(r);
      exp_q.push_back(r);
    end
    plan_fill = fc;
  endfunction

  task automatic seed_entry(input int base, j, v);
    int a, c;
    a = (base + 2 * j) & 65535;
    c = $urandom_range(1, 255);
    mem[a[15:0]] = 8'(v); ref_mem[a[15:0]] = 8'(v);
    a = (a + 1) & 65535;
    mem[a[15:0]] = 8'(c); ref_mem[a[15:0]] = 8'(c);
  endtask

  task automatic seed_random(input int base, k);
    for (int j = 0; j < k; j++)
      seed_entry(base, j, ($urandom_range(0, 99) < 40) ? 0 : $urandom_range(1, 255));
  endtask

  task automatic do_run(input int base, k, dec, hold, abort_at, output int done_cycle);
    rec_t r;
    int   n, bad, a;
    done_cycle = -1;
    @(negedge clk);
    add = 16'(base); k_in = 10'(k); decay = 8'(dec); hold_en = 1'(hold); start = 1'b1;
    @(posedge clk);
    plan_run(base, k, dec, hold, abort_at);
    for (n = 1; n <= 6000; n++) begin
      @(negedge clk); #1;
      if (n == 1) begin
        add = 16'($urandom); k_in = 10'($urandom); decay = 8'($urandom); hold_en = 1'($urandom);
        if (abort_at >= 0) start = 1'b0;
      end
      abort_r = (abort_at >= 0 && n == abort_at + 1);
      if (done && done_cycle < 0) done_cycle = n;
      if (exp_q.size() == 0) break;
    end
    abort_r = 1'b0;
    if (exp_q.size() != 0) begin
      chk("run_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    if (abort_at < 0) begin
      start = 1'b0;
      @(posedge clk);
      r.en = 0; r.we = 0; r.addr = 0; r.data = 0; r.busy = 0; r.done = 0; r.fill = plan_fill;
      exp_q.push_back(r);
      @(negedge clk); #1;
    end
    start = 1'b0;
    if (k > 0) begin
      bad = 0;
      for (int j = 0; j < 2 * k; j++) begin
        a = (base + j) & 65535;
        if (mem[a[15:0]] !== ref_mem[a[15:0]]) bad++;
      end
      chk("mem_region", bad, 0);
    end
  endtask

  initial begin
    int dc, k, ab;
    rst = 1'b1; start = 1'b0; abort_r = 1'b0; hold_en = 1'b0;
    add = '0; k_in = '0; decay = '0; mem_rdata = '0;
    for (int i = 0; i < 65536; i++) begin mem[i] = 8'(i * 7); ref_mem[i] = 8'(i * 7); end

    fork
      // Single-port synchronous memory: write on strobe, read data valid the next cycle.
      forever begin
        @(posedge clk);
        if (mem_en) begin
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata <= mem[mem_addr];
        end
      end
      // Compare process: every planned cycle is checked against the DUT outputs.
      forever begin
        rec_t r;
        bit   ok;
        @(negedge clk);
        if (exp_q.size() > 0) begin
          r  = exp_q.pop_front();
          ok = (int'(mem_en) == r.en) && (int'(mem_we) == r.we) && (int'(busy) == r.busy) &&
               (int'(done) == r.done) && (int'(fill) == r.fill) &&
               (r.en == 0 || int'(mem_addr) == r.addr) && (r.we == 0 || int'(mem_wdata) == r.data);
          n_checks++;
          if (ok) n_pass++;
          else $display("FAIL cycle: got en=%0d we=%0d addr=%h data=%0d busy=%0d done=%0d fill=%0d expected en=%0d we=%0d addr=%h data=%0d busy=%0d done=%0d fill=%0d",
                        mem_en, mem_we, mem_addr, mem_wdata, busy, done, fill,
                        r.en, r.we, r.addr, r.data, r.busy, r.done, r.fill);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    #1;
    chk("reset_en", int'(mem_en), 0);
    chk("reset_we", int'(mem_we), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_fill", int'(fill), 0);
    @(negedge clk); rst = 1'b0;

    seed_entry(16'h0100, 0, 5); seed_entry(16'h0100, 1, 0);
    seed_entry(16'h0100, 2, 0); seed_entry(16'h0100, 3, 7);
    do_run(16'h0100, 4, 1, 1, -1, dc);
    chk("t1_done_cycle", dc, 17);
    chk("t1_fill", int'(fill), 2);
    chk("t1_v0", int'(mem[16'h0100]), 5);  chk("t1_c0", int'(mem[16'h0101]), 31);
    chk("t1_v1", int'(mem[16'h0102]), 5);  chk("t1_c1", int'(mem[16'h0103]), 30);
    chk("t1_v2", int'(mem[16'h0104]), 5);  chk("t1_c2", int'(mem[16'h0105]), 29);
    chk("t1_v3", int'(mem[16'h0106]), 7);  chk("t1_c3", int'(mem[16'h0107]), 31);

    seed_entry(16'h0100, 0, 5); seed_entry(16'h0100, 1, 0);
    seed_entry(16'h0100, 2, 0); seed_entry(16'h0100, 3, 7);
    do_run(16'h0100, 4, 10, 0, -1, dc);
    chk("t2_v1", int'(mem[16'h0102]), 0);  chk("t2_c1", int'(mem[16'h0103]), 21);
    chk("t2_v2", int'(mem[16'h0104]), 0);  chk("t2_c2", int'(mem[16'h0105]), 11);
    chk("t2_c3", int'(mem[16'h0107]), 31);
    chk("t2_fill", int'(fill), 2);

    do_run(16'h0300, 0, 3, 1, -1, dc);
    chk("k0_done_cycle", dc, 1);

    seed_entry(16'hFFFE, 0, 3); seed_entry(16'hFFFE, 1, 0);
    do_run(16'hFFFE, 2, 1, 1, -1, dc);
    chk("wrap_v1", int'(mem[16'h0000]), 3);
    chk("wrap_c1", int'(mem[16'h0001]), 30);

    seed_random(16'h0400, 6);
    do_run(16'h0400, 6, 2, 1, 8, dc);
    chk("abort_no_done", dc, -1);
    seed_random(16'h0500, 5);
    do_run(16'h0500, 5, 3, 1, -1, dc);

    seed_entry(16'h0600, 0, 9); seed_entry(16'h0600, 1, 0); seed_entry(16'h0600, 2, 0);
    @(negedge clk);
    add = 16'h0600; k_in = 10'd3; decay = 8'd1; hold_en = 1'b1; start = 1'b1;
    @(posedge clk);
    plan_run(16'h0600, 3, 1, 1, -1);
    repeat (3) @(negedge clk);
    #1;
    exp_q.delete();
    start = 1'b0;
    chk("rst_pre_we", int'(mem_we), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_en", int'(mem_en), 0);
    chk("rst_async_we", int'(mem_we), 0);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_data", int'(mem_wdata), 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    seed_entry(16'h0700, 0, 0); seed_entry(16'h0700, 1, 0);
    do_run(16'h0700, 2, 40, 1, -1, dc);
    chk("rst_run_v0", int'(mem[16'h0700]), 0);
    chk("rst_run_c0", int'(mem[16'h0701]), 0);
    chk("rst_run_c1", int'(mem[16'h0703]), 0);

    seed_random(16'h0800, 8);
    do_run(16'h0800, 8, 0, 1, -1, dc);
    seed_random(16'h0900, 8);
    do_run(16'h0900, 8, 200, 1, -1, dc);
    seed_random(16'h2000, 1023);
    do_run(16'h2000, 1023, 1, 1, -1, dc);
    chk("kmax_done_cycle", dc, 4 * 1023 + 1);

    for (int t = 0; t < 30; t++) begin
      int base;
      base = $urandom_range(0, 65535);
      k    = $urandom_range(1, 12);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * k - 1) : -1;
      seed_random(base, k);
      do_run(base, k, $urandom_range(0, 40), $urandom_range(0, 1), ab, dc);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
